// File: rtl/sdp_pkg.sv
// Shared SDP definitions: default bus widths, transaction record, GPIO register map
// and a helper for sizing requester-index fields.
package sdp_pkg;

  localparam int SDP_ADDR_W = 1;
  localparam int SDP_DATA_W = 1;

  localparam logic [SDP_ADDR_W-1:0] GPIO_ADDR_RD = SDP_ADDR_W'(0);
  localparam logic [SDP_ADDR_W-1:0] GPIO_ADDR_WR = SDP_ADDR_W'(1);

  typedef struct packed {
    logic                  we;
    logic [SDP_ADDR_W-1:0] addr;
    logic [SDP_DATA_W-1:0] wd;
  } sdp_txn_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdp_arb_if.sv
// Requester-side and peripheral-side signals of the SDP arbiter, bundled as one interface.
interface sdp_arb_if #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 1,
  parameter int DATA_W = 1
);

  logic [NREQ-1:0]        req_i;
  logic [NREQ-1:0]        req_we_i;
  logic [NREQ*ADDR_W-1:0] req_a_i;
  logic [NREQ*DATA_W-1:0] req_wd_i;
  logic [NREQ-1:0]        gnt_o;
  logic [NREQ-1:0]        rvalid_o;
  logic [NREQ*DATA_W-1:0] rdata_o;

  logic [ADDR_W-1:0] wa;
  logic              we;
  logic [DATA_W-1:0] wd;
  logic [ADDR_W-1:0] ra;
  logic              re;
  logic [DATA_W-1:0] rd;

  modport slave (
    input  req_i, req_we_i, req_a_i, req_wd_i, rd,
    output gnt_o, rvalid_o, rdata_o, wa, we, wd, ra, re
  );

  modport master (
    output req_i, req_we_i, req_a_i, req_wd_i, rd,
    input  gnt_o, rvalid_o, rdata_o, wa, we, wd, ra, re
  );

endinterface

// File: rtl/sdp_arb_rr_arbiter.sv
// Combinational one-hot round-robin picker: searches upward from i_last+1, wrapping,
// and grants the first requester found.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [NREQ-1:0]  o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] idx;
    // NOTE: every output and temporary gets a default before the loop so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    o_gnt     = '0;
    o_gnt_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IDX_W'((int'(i_last) + i) % NREQ);
      if (!found && i_req[idx]) begin
        found      = 1'b1;
        o_gnt[idx] = 1'b1;
        o_gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/sdp_arb.sv
// Round-robin arbiter sharing one SDP peripheral port among NREQ requesters, with a
// registered issue stage and a response stage that steers read data to its owner.
module sdp_arb
  import sdp_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = SDP_ADDR_W,
  parameter int DATA_W = SDP_DATA_W
) (
  input logic   clk,
  input logic   rst_n,
  sdp_arb_if.slave bus
);

  localparam int IDX_W = idx_width(NREQ);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
  } txn_t;

  logic [NREQ-1:0]   w_gnt;
  logic [IDX_W-1:0]  w_gnt_idx;
  logic              w_any_gnt;
  txn_t              w_txn;
  logic [ADDR_W-1:0] w_req_a  [NREQ];
  logic [DATA_W-1:0] w_req_wd [NREQ];

  logic [IDX_W-1:0]  r_last;
  logic              r_we;
  logic              r_re;
  logic [ADDR_W-1:0] r_wa;
  logic [ADDR_W-1:0] r_ra;
  logic [DATA_W-1:0] r_wd;
  logic [IDX_W-1:0]  r_iss_owner;
  logic              r_rsp_rd;
  logic [IDX_W-1:0]  r_rsp_owner;
  logic [NREQ-1:0]   r_rvalid;
  logic [DATA_W-1:0] r_rdata [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_flat
    assign w_req_a[g]  = bus.req_a_i[g*ADDR_W +: ADDR_W];
    assign w_req_wd[g] = bus.req_wd_i[g*DATA_W +: DATA_W];
    assign bus.rdata_o[g*DATA_W +: DATA_W] = r_rdata[g];
  end

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .i_req     (bus.req_i),
    .i_last    (r_last),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign w_any_gnt = |w_gnt;

  always_comb begin
    w_txn.we   = bus.req_we_i[w_gnt_idx];
    w_txn.addr = w_req_a[w_gnt_idx];
    w_txn.wd   = w_req_wd[w_gnt_idx];
  end

  // Issue stage: the winning transaction drives the peripheral port for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last      <= IDX_W'(NREQ - 1);
      r_we        <= 1'b0;
      r_re        <= 1'b0;
      r_wa        <= '0;
      r_ra        <= '0;
      r_wd        <= '0;
      r_iss_owner <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop samples
      // pre-edge values, independent of statement order.
      r_we <= w_any_gnt &&  w_txn.we;
      r_re <= w_any_gnt && !w_txn.we;
      if (w_any_gnt) begin
        r_last      <= w_gnt_idx;
        r_iss_owner <= w_gnt_idx;
        if (w_txn.we) begin
          r_wa <= w_txn.addr;
          r_wd <= w_txn.wd;
        end else begin
          r_ra <= w_txn.addr;
        end
      end
    end
  end

  // Response stage: tags trail the peripheral's registered read by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_rd    <= 1'b0;
      r_rsp_owner <= '0;
      r_rvalid    <= '0;
      // NOTE: the read-data holding registers are architecturally visible outputs,
      // so they are reset like any other flop rather than left as uninitialised storage.
      r_rdata     <= '{default: '0};
    end else begin
      r_rsp_rd    <= r_re;
      r_rsp_owner <= r_iss_owner;
      r_rvalid    <= '0;
      if (r_rsp_rd) begin
        r_rvalid[r_rsp_owner] <= 1'b1;
        r_rdata[r_rsp_owner]  <= bus.rd;
      end
    end
  end

  assign bus.gnt_o    = w_gnt;
  assign bus.rvalid_o = r_rvalid;
  assign bus.we       = r_we;
  assign bus.re       = r_re;
  assign bus.wa       = r_wa;
  assign bus.ra       = r_ra;
  assign bus.wd       = r_wd;

endmodule

// File: doc/sdp_arb.md
# sdp_arb

Round-robin arbiter that shares one SDP memory-access port (wa/we/wd, ra/re/rd) between NREQ requesters, such as the core load/store unit and the debug host. It sits between the requesters and a single SDP peripheral such as the GPIO block. It accepts at most one transaction per cycle, issues it to the peripheral through a registered stage, and routes read data back to the owning requester. Read data is held there until that requester's next read completes.

## Interface
- NREQ, 2, number of requesters (2..8)
- ADDR_W, 1, SDP address width
- DATA_W, 1, SDP data width
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- req_i  in  NREQ  per-requester request strobe; held until granted
- req_we_i  in  NREQ  1 = write, 0 = read
- req_a_i  in  NREQ*ADDR_W  flattened address, requester k at [k*ADDR_W +: ADDR_W]
- req_wd_i  in  NREQ*DATA_W  flattened write data
- gnt_o  out  NREQ  one-hot grant, combinational, same cycle as accepted req
- rvalid_o  out  NREQ  one-cycle pulse: read data for requester k valid
- rdata_o  out  NREQ*DATA_W  per-requester read-data hold register
- wa, we, wd  out  ADDR_W, 1, DATA_W  SDP write port, registered
- ra, re  out  ADDR_W, 1  SDP read port, registered
- rd  in  DATA_W  SDP read data, registered by the peripheral one cycle after re

## Operation
- Arbitration:
  - Round-robin over requesters with req_i set.
  - Priority pointer `last` holds the most recently granted index; search order is last+1 upward, wrapping modulo NREQ.
  - `last` updates only on a grant.
  - Reset sets last = NREQ-1, so requester 0 has top priority.
- gnt_o: at most one bit set per cycle; zero when no request is pending.
- Request fields (we, a, wd) must be stable while req_i is high and gnt_o is low. Deasserting req before grant is legal and drops the request.
- Issue stage, loaded on any grant:
  - Write: we=1, wa=addr, wd=data, re=0.
  - Read: re=1, ra=addr, we=0.
  - Also stores owner index and is_read.
  - No grant: we=re=0; wa/ra/wd keep their previous values.
- Response stage: owner and is_read shift one stage further. When that stage holds a read, rd is captured into rdata_o[owner] and rvalid_o[owner] pulses the following cycle.
- Writes produce no rvalid.
- Full pipelining: a new grant is allowed every cycle, and transactions complete in grant order.
- Reset values: gnt_o comb 0 (no req), rvalid_o=0, rdata_o=0, we=re=0, wa=ra=wd=0, pipeline tags invalid.

## Timing
- Cycle N: req seen and gnt_o high.
- Edge N→N+1: issue register loaded; we/re visible during N+1.
- Edge N+1→N+2: peripheral samples we/re; rd valid during N+2.
- Edge N+2→N+3: rdata_o[k] loaded and rvalid_o[k] high for cycle N+3 only.
- Read latency is 3 cycles from gnt to rvalid; throughput is 1 transaction per cycle.
- Write followed by read to the same address, granted in consecutive cycles: the read returns the new value. The write commits at edge N+1→N+2 and the read samples at the next edge.
- Simultaneous requests: exactly one is granted; the others wait with no starvation, at most NREQ-1 cycles of waiting per request.
- Reset mid-operation:
  - In-flight transactions are discarded and no rvalid is produced.
  - All outputs return to reset values asynchronously.
  - Arbitration resumes from requester 0.

## Structure
- The shared package sdp_pkg holds:
  - The SDP transaction struct {we, addr, wd} parameterised by ADDR_W/DATA_W. Use localparam widths or a macro if the tool lacks parameterised structs.
  - The GPIO register address constants GPIO_ADDR_RD=0 and GPIO_ADDR_WR=1.
- Sub-module rr_arbiter: a purely combinational one-hot round-robin picker with inputs req and last, and outputs gnt and gnt_idx.
- sdp_arb owns the `last` register, the issue and response pipeline registers, and the rdata/rvalid outputs.

## Test plan
- Reset, then a single read: requester 0 reads addr 0 with the peripheral input at 1. Expect gnt_o=01 in cycle N, re=1 in N+1, rvalid_o=01 in N+3, and rdata_o[0]=1 held afterwards.
- Both requesters continuously request reads from cycle 0. Expect grants alternating 01,10,01,10 and rvalid following the same pattern 3 cycles later.
- Requester 1 writes 1 to addr 1 while requester 0 simultaneously reads addr 1. Expect requester 0 granted first (after reset) with rdata 0, requester 1 granted next cycle, and a repeated read returning 1.
- Back-to-back reads by requester 0 with the peripheral input toggling 0→1. Expect two rvalid pulses on consecutive cycles, and rdata_o[0] updating 0 then 1 and holding.
- Assert rst_n=0 one cycle after a read grant. Expect no rvalid; rdata_o, we, re all 0; the first post-reset grant goes to requester 0.
- Write-only traffic from both requesters. Expect rvalid_o to stay 0 throughout and the peripheral we high on every cycle after the first grant.
